// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo slew / PWM chain.
package servo_pkg;

  localparam int MAG_W = 17;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } slew_state_t;

  localparam int unsigned SERVO_MAX_MAG = 22800;
  localparam int unsigned SERVO_CENTRE  = 11400;

  function automatic mag_t clamp_mag(input mag_t value, input mag_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Frame-rate prescaler: one-cycle registered strobe every TICK_DIV clocks,
// first strobe TICK_DIV cycles after reset release.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/servo_slew.sv
// Clamps commanded servo targets and slews the PWM magnitude toward them,
// at most STEP per frame tick.
//
//   state | meaning
//   IDLE  | magnitude == target
//   UP    | magnitude <  target, stepping up on each tick
//   DOWN  | magnitude >  target, stepping down on each tick
module servo_slew
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned STEP     = 240,
  parameter int unsigned MAX_MAG  = SERVO_MAX_MAG,
  parameter int unsigned INIT_MAG = SERVO_CENTRE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MAG_W-1:0] cmd_target,
  input  logic             hold,
  output logic [MAG_W-1:0] magnitude,
  output logic             at_target,
  output logic             tick
);

  localparam mag_t             MAX_M  = mag_t'(MAX_MAG);
  localparam mag_t             INIT_M = mag_t'(INIT_MAG);
  localparam logic [MAG_W:0]   STEP_X = (MAG_W + 1)'(STEP);

  if (INIT_MAG > MAX_MAG) begin : g_bad_init
    $error("servo_slew: INIT_MAG must not exceed MAX_MAG");
  end
  if (STEP < 1) begin : g_bad_step
    $error("servo_slew: STEP must be at least 1");
  end

  logic tick_i;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_i)
  );

  assign tick = tick_i;

  slew_state_t    state;
  slew_state_t    state_nx;
  mag_t           target;
  mag_t           target_nx;
  mag_t           mag_nx;
  logic [MAG_W:0] diff;
  logic [MAG_W:0] delta;

  // The step uses the target held before this edge; a command landing on a
  // tick only takes effect from the following tick.
  always_comb begin
    target_nx = target;
    if (cmd_valid && cmd_ready) begin
      target_nx = clamp_mag(cmd_target, MAX_M);
    end

    diff   = '0;
    delta  = '0;
    mag_nx = magnitude;
    if (tick_i && !hold) begin
      unique case (state)
        UP: begin
          diff   = {1'b0, target} - {1'b0, magnitude};
          delta  = (diff > STEP_X) ? STEP_X : diff;
          mag_nx = mag_t'({1'b0, magnitude} + delta);
        end
        DOWN: begin
          diff   = {1'b0, magnitude} - {1'b0, target};
          delta  = (diff > STEP_X) ? STEP_X : diff;
          mag_nx = mag_t'({1'b0, magnitude} - delta);
        end
        default: mag_nx = magnitude;
      endcase
    end

    if (mag_nx == target_nx) begin
      state_nx = IDLE;
    end else if (mag_nx < target_nx) begin
      state_nx = UP;
    end else begin
      state_nx = DOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      target    <= INIT_M;
      magnitude <= INIT_M;
      state     <= IDLE;
      at_target <= 1'b1;
    end else begin
      cmd_ready <= 1'b1;
      target    <= target_nx;
      magnitude <= mag_nx;
      state     <= state_nx;
      at_target <= (state_nx == IDLE);
    end
  end

endmodule
